// File: rtl/inst_cache_assoc.sv
// N-way set-associative read-only instruction cache with LRU replacement,
// flush, and saturating hit/miss counters. Lines are refilled whole from
// off-chip memory; the requested word is returned one cycle after a hit
// or in the RESPOND cycle that follows a refill.
module inst_cache_assoc #(
  parameter int ADDR_W         = 8,
  parameter int INST_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 4,
  parameter int NUM_WAYS       = 2,
  parameter int CNT_W          = 16
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      read_enable,
  input  logic [ADDR_W-1:0]                         address,
  input  logic                                      flush,
  output logic                                      rd_ready,
  output logic [INST_W-1:0]                         inst,
  output logic                                      mem_read_enable,
  output logic [ADDR_W-$clog2(WORDS_PER_LINE)-1:0]  mem_address,
  input  logic                                      mem_data_ready,
  input  logic [INST_W*WORDS_PER_LINE-1:0]          mem_data,
  output logic [CNT_W-1:0]                          hit_count,
  output logic [CNT_W-1:0]                          miss_count
);

  localparam int LINE_W = INST_W * WORDS_PER_LINE;
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  // Replacement state per set: bit0 = 2-way LRU or tree root; bits1/2 = 4-way leaves
  logic [2:0]            lru_q   [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]     data_q  [NUM_SETS][NUM_WAYS];
  logic [ADDR_W-1:0]     req_q;
  logic                  rd_ready_q;
  logic [INST_W-1:0]     inst_q;
  logic                  mre_q;
  logic [ADDR_W-OFF_W-1:0] maddr_q;
  logic [CNT_W-1:0]      hit_q, miss_q;

  logic [TAG_W-1:0]      a_tag, r_tag;
  logic [IDX_W-1:0]      a_idx, r_idx;
  logic [OFF_W-1:0]      a_off, r_off;
  logic                  hit, accept, hit_acc, miss_acc, inv_found;
  logic [WAY_W-1:0]      hit_way, victim;
  logic [1:0]            lru_way;

  assign a_tag = address[ADDR_W-1 -: TAG_W];
  assign a_idx = address[OFF_W +: IDX_W];
  assign a_off = address[OFF_W-1:0];
  assign r_tag = req_q[ADDR_W-1 -: TAG_W];
  assign r_idx = req_q[OFF_W +: IDX_W];
  assign r_off = req_q[OFF_W-1:0];

  assign accept   = (state_q == IDLE) && read_enable && !flush;
  assign hit_acc  = accept && hit;
  assign miss_acc = accept && !hit;

  // Mark way w most-recently-used: each tree node is pointed away from w
  function automatic logic [2:0] lru_touch(input logic [2:0] cur, input logic [1:0] w);
    logic [2:0] nxt;
    nxt = cur;
    if (NUM_WAYS == 2) begin
      nxt[0] = ~w[0];
    end else if (NUM_WAYS == 4) begin
      nxt[0] = ~w[1];
      if (w[1]) nxt[2] = ~w[0];
      else      nxt[1] = ~w[0];
    end
    return nxt;
  endfunction

  // Tag lookup across all ways of the addressed set; lowest matching way wins
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[a_idx][w] && (tag_q[a_idx][w] == a_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim selection: lowest invalid way, otherwise the LRU way
  always_comb begin
    inv_found = 1'b0;
    lru_way   = 2'b00;
    if (NUM_WAYS == 2)
      lru_way = {1'b0, lru_q[r_idx][0]};
    else if (NUM_WAYS == 4)
      lru_way = {lru_q[r_idx][0], lru_q[r_idx][0] ? lru_q[r_idx][2] : lru_q[r_idx][1]};
    victim = WAY_W'(lru_way);
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!inv_found && !valid_q[r_idx][w]) begin
        inv_found = 1'b1;
        victim    = WAY_W'(w);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state; flush outranks a same-cycle read, busy states ignore both
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush) state_d = FLUSH;
               else if (miss_acc) state_d = REFILL;
      REFILL:  if (mem_data_ready) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control, valid/LRU state, response and counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        lru_q[s]   <= '0;
      end
      req_q      <= '0;
      rd_ready_q <= 1'b0;
      inst_q     <= '0;
      mre_q      <= 1'b0;
      maddr_q    <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      rd_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hit_acc) begin
            rd_ready_q   <= 1'b1;
            inst_q       <= data_q[a_idx][hit_way][a_off*INST_W +: INST_W];
            lru_q[a_idx] <= lru_touch(lru_q[a_idx], 2'(hit_way));
            if (hit_q != '1) hit_q <= hit_q + 1'b1;
          end else if (miss_acc) begin
            req_q   <= address;
            mre_q   <= 1'b1;
            maddr_q <= address[ADDR_W-1:OFF_W];
            if (miss_q != '1) miss_q <= miss_q + 1'b1;
          end
        end
        REFILL: begin
          if (mem_data_ready) begin
            mre_q                  <= 1'b0;
            valid_q[r_idx][victim] <= 1'b1;
            lru_q[r_idx]           <= lru_touch(lru_q[r_idx], 2'(victim));
            rd_ready_q             <= 1'b1;
            inst_q                 <= mem_data[r_off*INST_W +: INST_W];
          end
        end
        FLUSH: begin
          for (int unsigned s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays: written only on refill, never cleared
  always_ff @(posedge clock) begin
    if (reset && (state_q == REFILL) && mem_data_ready) begin
      tag_q[r_idx][victim]  <= r_tag;
      data_q[r_idx][victim] <= mem_data;
    end
  end

  assign rd_ready        = rd_ready_q;
  assign inst            = inst_q;
  assign mem_read_enable = mre_q;
  assign mem_address     = maddr_q;
  assign hit_count       = hit_q;
  assign miss_count      = miss_q;

endmodule

// File: tb/tb_inst_cache_assoc.sv
// Scoreboard bench for inst_cache_assoc: three geometries (2-way default,
// 1-way with 4-bit counters, 4-way), a latency-programmable memory model,
// and a monitor that pops expected instructions on every rd_ready.
module tb_inst_cache_assoc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        re    [3];
  logic [7:0]  addr  [3];
  logic        fl    [3];
  logic        stray [3];
  logic        mdr   [3];
  logic [63:0] mdat  [3];
  logic        rdy   [3];
  logic [15:0] inst_w[3];
  logic        mre   [3];
  logic [5:0]  maddr [3];
  logic [15:0] hcw   [3];
  logic [15:0] mcw   [3];

  typedef struct packed {
    logic [1:0]  dut;
    logic [15:0] d;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 5;
  int exph[3];
  int expm[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NW = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    localparam int CW = (g == 1) ? 4 : 16;
    logic [CW-1:0] hc, mc;
    inst_cache_assoc #(.NUM_WAYS(NW), .CNT_W(CW)) u_dut (
      .clock          (clk),
      .reset          (rst_n),
      .read_enable    (re[g]),
      .address        (addr[g]),
      .flush          (fl[g]),
      .rd_ready       (rdy[g]),
      .inst           (inst_w[g]),
      .mem_read_enable(mre[g]),
      .mem_address    (maddr[g]),
      .mem_data_ready (mdr[g] | stray[g]),
      .mem_data       (mdat[g]),
      .hit_count      (hc),
      .miss_count     (mc)
    );
    assign hcw[g] = 16'(hc);
    assign mcw[g] = 16'(mc);
  end

  // Memory contents: line 1 is the fixed pattern, others encode {line, word, 8'h3C}
  function automatic logic [63:0] line_data(input logic [5:0] la);
    logic [63:0] l;
    l = '0;
    if (la == 6'd1) return 64'h4444_3333_2222_1111;
    for (int k = 0; k < 4; k++) l[k*16 +: 16] = {la, 2'(k), 8'h3C};
    return l;
  endfunction

  function automatic logic [15:0] expw(input logic [7:0] a);
    logic [63:0] l;
    l = line_data(a[7:2]);
    return l[a[1:0]*16 +: 16];
  endfunction

  function automatic int cmax(input int g);
    return (g == 1) ? 15 : 65535;
  endfunction

  // Memory model: answers a held request after 'lat' idle cycles
  initial begin
    int cnt[3];
    for (int g = 0; g < 3; g++) begin
      mdr[g] = 1'b0; mdat[g] = 64'hBAD0_BAD0_BAD0_BAD0; cnt[g] = 0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (mre[g] === 1'b1) begin
          if (cnt[g] == lat) begin
            mdr[g] = 1'b1; mdat[g] = line_data(maddr[g]); cnt[g] = 0;
          end else begin
            mdr[g] = 1'b0; mdat[g] = 64'hBAD0_BAD0_BAD0_BAD0; cnt[g]++;
          end
        end else begin
          mdr[g] = 1'b0; mdat[g] = 64'hBAD0_BAD0_BAD0_BAD0; cnt[g] = 0;
        end
      end
    end
  end

  // Monitor: every rd_ready must match the oldest expected response
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (rdy[g] === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rd_ready: dut%0d inst=%h, no response expected", g, inst_w[g]);
        end else begin
          e = sb.pop_front();
          if (e.dut != 2'(g) || e.d !== inst_w[g]) begin
            n_fail++;
            $display("FAIL rd_data: got dut%0d inst=%h, expected dut%0d inst=%h", g, inst_w[g], e.dut, e.d);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input int g);
    chk("hit_count", hcw[g], 64'(exph[g]));
    chk("miss_count", mcw[g], 64'(expm[g]));
  endtask

  task automatic wait_drain();
    int i = 0;
    while (sb.size() != 0 && i < 60) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic req(input int g, input logic [7:0] a, input bit hit, input logic [15:0] d);
    exp_t e;
    e.dut = 2'(g);
    e.d   = d;
    sb.push_back(e);
    re[g] = 1'b1; addr[g] = a;
    @(negedge clk);
    re[g] = 1'b0;
    if (hit) begin
      chk("hit_latency", rdy[g], 1);
      chk("hit_no_mem_req", mre[g], 0);
      if (exph[g] < cmax(g)) exph[g]++;
    end else begin
      chk("miss_mem_req", mre[g], 1);
      chk("miss_mem_addr", maddr[g], a[7:2]);
      if (expm[g] < cmax(g)) expm[g]++;
    end
    wait_drain();
  endtask

  task automatic do_flush(input int g);
    fl[g] = 1'b1;
    @(negedge clk);
    fl[g] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      re[g] = 1'b0; addr[g] = '0; fl[g] = 1'b0; stray[g] = 1'b0;
      exph[g] = 0; expm[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset_rd_ready", rdy[g], 0);
      chk("reset_inst", inst_w[g], 0);
      chk("reset_mem_read_enable", mre[g], 0);
      chk("reset_mem_address", maddr[g], 0);
      chk_cnt(g);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss then hit in the same line
    lat = 5;
    req(0, 8'h05, 0, 16'h2222);
    chk("t1_miss_count", mcw[0], 1);
    req(0, 8'h07, 1, 16'h4444);
    chk("t1_hit_count", hcw[0], 1);

    // Read held with a new address during REFILL is ignored
    e.dut = 2'd0; e.d = 16'h153C;
    sb.push_back(e);
    re[0] = 1'b1; addr[0] = 8'h15;
    @(negedge clk);
    addr[0] = 8'h25;
    chk("busy_mem_req", mre[0], 1);
    chk("busy_mem_addr", maddr[0], 6'h05);
    repeat (2) @(negedge clk);
    chk("busy_mem_addr_stable", maddr[0], 6'h05);
    re[0] = 1'b0;
    expm[0]++;
    wait_drain();
    chk_cnt(0);

    // LRU in set 0: 0x20 evicts 0x10, so 0x00 survives and 0x10 misses
    req(0, 8'h00, 0, expw(8'h00));
    req(0, 8'h10, 0, expw(8'h10));
    req(0, 8'h00, 1, expw(8'h00));
    req(0, 8'h20, 0, expw(8'h20));
    req(0, 8'h00, 1, expw(8'h00));
    req(0, 8'h10, 0, expw(8'h10));
    chk_cnt(0);

    // Flush beats a same-cycle read, then the line misses again
    req(0, 8'h05, 1, 16'h2222);
    fl[0] = 1'b1; re[0] = 1'b1; addr[0] = 8'h05;
    @(negedge clk);
    fl[0] = 1'b0; re[0] = 1'b0;
    chk("flush_drop_no_mem", mre[0], 0);
    chk("flush_drop_no_rdy", rdy[0], 0);
    repeat (3) @(negedge clk);
    chk_cnt(0);
    req(0, 8'h05, 0, 16'h2222);
    chk_cnt(0);

    // Memory latency 0 and 10 return identical data
    lat = 0;
    do_flush(0);
    req(0, 8'h05, 0, 16'h2222);
    req(0, 8'h07, 1, 16'h4444);
    lat = 10;
    do_flush(0);
    req(0, 8'h05, 0, 16'h2222);
    req(0, 8'h07, 1, 16'h4444);
    chk_cnt(0);

    // Reset during REFILL aborts at once; a later stray data pulse is ignored
    re[0] = 1'b1; addr[0] = 8'h09;
    @(negedge clk);
    re[0] = 1'b0;
    @(negedge clk);
    chk("t4_refill_active", mre[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_mem_read_enable", mre[0], 0);
    chk("t4_async_mem_address", maddr[0], 0);
    chk("t4_async_rd_ready", rdy[0], 0);
    chk("t4_async_inst", inst_w[0], 0);
    for (int g = 0; g < 3; g++) begin exph[g] = 0; expm[g] = 0; end
    chk_cnt(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray[0] = 1'b1;
    @(negedge clk);
    stray[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_stray_ignored", mre[0], 0);
    chk_cnt(0);
    req(0, 8'h05, 0, 16'h2222);
    chk_cnt(0);

    // Direct-mapped thrash and 4-bit counter saturation
    lat = 2;
    req(1, 8'h00, 0, expw(8'h00));
    req(1, 8'h10, 0, expw(8'h10));
    req(1, 8'h00, 0, expw(8'h00));
    req(1, 8'h10, 0, expw(8'h10));
    chk_cnt(1);
    for (int i = 0; i < 20; i++) req(1, 8'h10 + 8'(i % 4), 1, expw(8'h10 + 8'(i % 4)));
    chk("sat_hit_count", hcw[1], 15);
    chk_cnt(1);

    // 4-way tree pseudo-LRU: after touching 0x00, 0x40 evicts 0x20
    req(2, 8'h00, 0, expw(8'h00));
    req(2, 8'h10, 0, expw(8'h10));
    req(2, 8'h20, 0, expw(8'h20));
    req(2, 8'h30, 0, expw(8'h30));
    req(2, 8'h00, 1, expw(8'h00));
    req(2, 8'h40, 0, expw(8'h40));
    req(2, 8'h00, 1, expw(8'h00));
    req(2, 8'h10, 1, expw(8'h10));
    req(2, 8'h30, 1, expw(8'h30));
    req(2, 8'h20, 0, expw(8'h20));
    chk_cnt(2);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
